// File: rtl/cpu6502_bus_pkg.sv
// Shared types and defaults for the 6502 internal bus fabric.
//   bus_word_t        one bus segment's worth of bits
//   BUS_DECAY_CYCLES  clocks an undriven segment keeps its charge
//   BUS_DECAY_VALUE   level a segment relaxes to once the charge has leaked away
//   SEG_*             conventional segment indices in the DB/SB/ADH chain
package cpu6502_bus_pkg;

  localparam int unsigned BUS_WIDTH = 8;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

  localparam int unsigned BUS_DECAY_CYCLES = 4;
  localparam bus_word_t   BUS_DECAY_VALUE  = '1;

  localparam int unsigned SEG_DB  = 0;
  localparam int unsigned SEG_SB  = 1;
  localparam int unsigned SEG_ADH = 2;

endpackage

// File: rtl/pass_segment_keeper.sv
// Dynamic charge keeper for one bus segment.
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset
//   group_driven_i  some member of this segment's group is driven this cycle
//   resolved_i      value the segment resolves to this cycle
//   retained_o      value the segment contributes when its group floats
module pass_segment_keeper #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      DECAY_CYCLES = 4,
  parameter logic [WIDTH-1:0] DECAY_VALUE  = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             group_driven_i,
  input  logic [WIDTH-1:0] resolved_i,
  output logic [WIDTH-1:0] retained_o
);

  localparam int unsigned     AgeW   = $clog2(DECAY_CYCLES + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(DECAY_CYCLES);

  logic [WIDTH-1:0] charge_q;
  logic [AgeW-1:0]  age_q, age_d;

  // Age saturates at AgeMax so a long-idle segment stays decayed.
  always_comb begin
    age_d = age_q;
    if (group_driven_i) begin
      age_d = '0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + AgeW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      charge_q <= DECAY_VALUE;
      age_q    <= AgeMax;
    end else begin
      charge_q <= resolved_i;
      age_q    <= age_d;
    end
  end

  // A fully aged segment has lost its charge; the register still tracks the bus.
  assign retained_o = (age_q == AgeMax) ? DECAY_VALUE : charge_q;

endmodule

// File: rtl/pass_bus_network.sv
// Pass-transistor bus fabric: a chain of SEGMENTS buses joined by SEGMENTS-1 pass switches.
// Each connected group resolves to the AND of its driven inputs, or to the AND of its
// members' retained charge when nothing drives it.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   bus_input       value driven onto each segment
//   bus_driven      per-segment drive enable
//   pass_enable     switch k joins segment k and k+1
//   bus_output      resolved value on each segment (combinational)
//   contention      two or more drivers in this segment's group (combinational)
//   contention_err  sticky contention flag, cleared only by reset
module pass_bus_network
  import cpu6502_bus_pkg::*;
#(
  parameter int unsigned      SEGMENTS     = 3,
  parameter int unsigned      WIDTH        = BUS_WIDTH,
  parameter int unsigned      DECAY_CYCLES = BUS_DECAY_CYCLES,
  parameter logic [WIDTH-1:0] DECAY_VALUE  = '1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SEGMENTS-1:0][WIDTH-1:0]     bus_input,
  input  logic [SEGMENTS-1:0]                bus_driven,
  input  logic [SEGMENTS-2:0]                pass_enable,
  output logic [SEGMENTS-1:0][WIDTH-1:0]     bus_output,
  output logic [SEGMENTS-1:0]                contention,
  output logic                               contention_err
);

  // Leftmost / rightmost segment index of each segment's group.
  int seg_lo [SEGMENTS];
  int seg_hi [SEGMENTS];

  logic [SEGMENTS-1:0][WIDTH-1:0] retained;
  logic [SEGMENTS-1:0]            group_driven;
  logic                           contention_err_q;

  always_comb begin
    seg_lo[0] = 0;
    for (int i = 1; i < int'(SEGMENTS); i++) begin
      seg_lo[i] = pass_enable[i-1] ? seg_lo[i-1] : i;
    end
    seg_hi[SEGMENTS-1] = int'(SEGMENTS) - 1;
    for (int i = int'(SEGMENTS) - 2; i >= 0; i--) begin
      seg_hi[i] = pass_enable[i] ? seg_hi[i+1] : i;
    end
  end

  for (genvar g = 0; g < int'(SEGMENTS); g++) begin : g_seg
    logic [WIDTH-1:0] driven_and;
    logic [WIDTH-1:0] retained_and;
    logic             any_drv;
    logic             multi_drv;

    // Undriven inputs are masked out so their value never reaches the output.
    always_comb begin
      driven_and   = '1;
      retained_and = '1;
      any_drv      = 1'b0;
      multi_drv    = 1'b0;
      for (int j = 0; j < int'(SEGMENTS); j++) begin
        if (j >= seg_lo[g] && j <= seg_hi[g]) begin
          if (bus_driven[j]) begin
            driven_and = driven_and & bus_input[j];
            multi_drv  = multi_drv | any_drv;
            any_drv    = 1'b1;
          end
          retained_and = retained_and & retained[j];
        end
      end
    end

    assign group_driven[g] = any_drv;
    assign contention[g]   = multi_drv;
    assign bus_output[g]   = any_drv ? driven_and : retained_and;

    pass_segment_keeper #(
      .WIDTH        (WIDTH),
      .DECAY_CYCLES (DECAY_CYCLES),
      .DECAY_VALUE  (DECAY_VALUE)
    ) u_keeper (
      .clk_i          (clk),
      .rst_i          (rst),
      .group_driven_i (group_driven[g]),
      .resolved_i     (bus_output[g]),
      .retained_o     (retained[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_err_q <= 1'b0;
    end else begin
      contention_err_q <= contention_err_q | (|contention);
    end
  end

  assign contention_err = contention_err_q;

endmodule
